// File: rtl/epu_job_scheduler.sv
// Sequences tiles through the EPU: waits for both SRAM buffers, launches the EPU,
// guards each tile with an optional watchdog, and retires the tile back to the DMAs.
module epu_job_scheduler #(
    parameter int TILE_W = 8,
    parameter int TMO_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic [TMO_W-1:0]  cfg_timeout,
    input  logic              go,
    input  logic              clr,
    input  logic              in_tile_valid,
    input  logic              out_buf_free,
    output logic              epu_start,
    input  logic              epu_end,
    output logic              in_tile_ack,
    output logic              out_tile_done,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              irq,
    output logic [TILE_W-1:0] tile_idx,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BUF = 3'd1,
        S_LAUNCH   = 3'd2,
        S_RUN      = 3'd3,
        S_RETIRE   = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    localparam logic [TILE_W-1:0] TILE_ONE = TILE_W'(1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

    state_t             state;
    logic [TILE_W-1:0]  tiles_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   wd_cnt;
    logic               settled;

    assign settled = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tiles_q  <= '0;
            tmo_q    <= '0;
            wd_cnt   <= '0;
            tile_idx <= '0;
            irq      <= 1'b0;
        end else begin
            irq <= 1'b0;
            // Shadow config only moves while no job is in flight.
            if (settled && cfg_we) begin
                tiles_q <= cfg_tiles;
                tmo_q   <= cfg_timeout;
            end
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (go) begin
                        tile_idx <= '0;
                        if (tiles_q != '0) begin
                            state <= S_WAIT_BUF;
                        end else begin
                            state <= S_DONE;
                            irq   <= 1'b1;
                        end
                    end else if (clr && state != S_IDLE) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT_BUF: begin
                    if (in_tile_valid && out_buf_free) state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    wd_cnt <= tmo_q;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    // A completion in the expiry cycle still counts as success.
                    if (epu_end) begin
                        state <= S_RETIRE;
                    end else if (tmo_q != '0) begin
                        wd_cnt <= wd_cnt - TMO_ONE;
                        if (wd_cnt == TMO_ONE) begin
                            state <= S_ERR;
                            irq   <= 1'b1;
                        end
                    end
                end
                S_RETIRE: begin
                    if (tile_idx == tiles_q - TILE_ONE) begin
                        state <= S_DONE;
                        irq   <= 1'b1;
                    end else begin
                        tile_idx <= tile_idx + TILE_ONE;
                        state    <= S_WAIT_BUF;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign epu_start     = (state == S_LAUNCH);
    assign in_tile_ack   = (state == S_RETIRE);
    assign out_tile_done = (state == S_RETIRE);
    assign busy          = (state == S_WAIT_BUF) || (state == S_LAUNCH) ||
                           (state == S_RUN) || (state == S_RETIRE);
    assign done          = (state == S_DONE);
    assign err_timeout   = (state == S_ERR);
    assign fsm_state     = state;

endmodule

// File: tb/tb_epu_job_scheduler.sv
// Directed bench for epu_job_scheduler: stimulus pushes expected output events,
// a negedge monitor pops and compares them whenever the DUT pulses an output.
module tb_epu_job_scheduler;

    localparam int TILE_W = 8;
    localparam int TMO_W  = 16;
    localparam int W      = 7 + TILE_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [TILE_W-1:0] cfg_tiles = '0;
    logic [TMO_W-1:0]  cfg_timeout = '0;
    logic              go = 1'b0;
    logic              clr = 1'b0;
    logic              in_tile_valid = 1'b1;
    logic              out_buf_free = 1'b1;
    logic              epu_start;
    logic              epu_end = 1'b0;
    logic              in_tile_ack;
    logic              out_tile_done;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic              irq;
    logic [TILE_W-1:0] tile_idx;
    logic [2:0]        fsm_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    epu_job_scheduler #(.TILE_W(TILE_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_tiles(cfg_tiles),
        .cfg_timeout(cfg_timeout), .go(go), .clr(clr),
        .in_tile_valid(in_tile_valid), .out_buf_free(out_buf_free),
        .epu_start(epu_start), .epu_end(epu_end), .in_tile_ack(in_tile_ack),
        .out_tile_done(out_tile_done), .busy(busy), .done(done),
        .err_timeout(err_timeout), .irq(irq), .tile_idx(tile_idx),
        .fsm_state(fsm_state)
    );

    // Clock and reset timing
    always #5 clk = ~clk;

    // Event word: start, ack, out_done, irq, done, err, busy, tile index
    function automatic logic [W-1:0] ev(input logic st, input logic ack, input logic ir,
                                        input logic dn, input logic er, input logic bz,
                                        input int idx);
        logic [TILE_W-1:0] i8;
        i8 = TILE_W'(idx);
        return {st, ack, ack, ir, dn, er, bz, i8};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every output pulse must match the head of the expected queue
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] req;
        if (!rst && (epu_start || in_tile_ack || out_tile_done || irq)) begin
            act = {epu_start, in_tile_ack, out_tile_done, irq, done, err_timeout, busy, tile_idx};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event actual=%0h required=none", act);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    errors++;
                    $display("FAIL event actual=%0h required=%0h", act, req);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int tiles, input int tmo);
        cfg_tiles   = TILE_W'(tiles);
        cfg_timeout = TMO_W'(tmo);
        cfg_we      = 1'b1;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!epu_start && n < 60) begin
            tick();
            n++;
        end
        check("start_wait", 32'(epu_start), 32'd1);
    endtask

    task automatic run_tile(input int gap);
        wait_start();
        repeat (gap) tick();
        epu_end = 1'b1;
        tick();
        epu_end = 1'b0;
        check("ack_latency", 32'(in_tile_ack), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && !err_timeout && n < 40) begin
            tick();
            n++;
        end
        check("done", 32'(done), 32'd1);
    endtask

    task automatic check_drain(input string name);
        tick();
        tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_tiles(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(ev(1, 0, 0, 0, 0, 1, i));
            exp_q.push_back(ev(0, 1, 0, 0, 0, 1, i));
        end
        exp_q.push_back(ev(0, 0, 1, 1, 0, 0, n - 1));
    endtask

    initial begin
        logic ok;

        // Reset state
        tick();
        tick();
        check("reset_outputs",
              32'({epu_start, in_tile_ack, out_tile_done, busy, done, err_timeout, irq, tile_idx, fsm_state}),
              32'd0);
        rst = 1'b0;
        tick();

        // Three tiles, no watchdog, EPU finishes 5 cycles after each start
        do_cfg(3, 0);
        push_tiles(3);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("busy_after_go", 32'(busy), 32'd1);
        tick();
        check("start_latency", 32'(epu_start), 32'd1);
        for (int i = 0; i < 3; i++) run_tile(5);
        wait_done();
        check("done_idx", 32'(tile_idx), 32'd2);
        check_drain("drain_three");

        // Output buffer held busy for 10 cycles after go
        do_cfg(2, 0);
        push_tiles(2);
        out_buf_free = 1'b0;
        pulse_go();
        ok = 1'b1;
        repeat (10) begin
            if (!busy || epu_start) ok = 1'b0;
            tick();
        end
        check("held_wait_buf", 32'(ok), 32'd1);
        out_buf_free = 1'b1;
        tick();
        check("delayed_start", 32'(epu_start), 32'd1);
        run_tile(3);
        run_tile(3);
        wait_done();
        check_drain("drain_bufwait");

        // Watchdog expiry with no completion
        do_cfg(1, 4);
        exp_q.push_back(ev(1, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(ev(0, 0, 1, 0, 1, 0, 0));
        pulse_go();
        wait_start();
        repeat (4) tick();
        check("wd_still_running", 32'({busy, err_timeout}), 32'b10);
        tick();
        check("wd_fire", 32'({err_timeout, irq, in_tile_ack}), 32'b110);
        tick();
        check("irq_single", 32'(irq), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_err", 32'({err_timeout, fsm_state}), 32'd0);
        check_drain("drain_timeout");

        // Completion on the last watchdog cycle wins over expiry
        do_cfg(1, 4);
        push_tiles(1);
        pulse_go();
        wait_start();
        repeat (4) tick();
        epu_end = 1'b1;
        tick();
        epu_end = 1'b0;
        check("end_wins", 32'({in_tile_ack, err_timeout}), 32'b10);
        wait_done();
        check_drain("drain_race");

        // Config write and go while running are ignored
        do_cfg(2, 0);
        push_tiles(2);
        pulse_go();
        wait_start();
        tick();
        cfg_tiles = 8'd7;
        cfg_we = 1'b1;
        go = 1'b1;
        tick();
        cfg_we = 1'b0;
        go = 1'b0;
        epu_end = 1'b1;
        tick();
        epu_end = 1'b0;
        run_tile(2);
        wait_done();
        check("tiles_kept", 32'(tile_idx), 32'd1);
        check_drain("drain_cfg_ignored");

        // Maximum tile count runs indices 0..254 without wrapping
        do_cfg(255, 0);
        push_tiles(255);
        pulse_go();
        for (int i = 0; i < 255; i++) run_tile(1);
        wait_done();
        check("max_last_idx", 32'(tile_idx), 32'd254);
        check_drain("drain_max");

        // Reset mid-run abandons the job and clears the shadow registers
        do_cfg(3, 0);
        exp_q.push_back(ev(1, 0, 0, 0, 0, 1, 0));
        pulse_go();
        wait_start();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("reset_mid_run",
              32'({epu_start, in_tile_ack, out_tile_done, busy, done, err_timeout, irq, tile_idx, fsm_state}),
              32'd0);
        rst = 1'b0;
        tick();
        check("reset_flushed", 32'(exp_q.size()), 32'd0);

        // Go with zero tiles completes immediately
        exp_q.push_back(ev(0, 0, 1, 1, 0, 0, 0));
        pulse_go();
        check("zero_tiles_done", 32'({done, busy, epu_start}), 32'b100);
        check_drain("drain_zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
